// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, funct encodings,
// divider FSM states and small arithmetic helpers.
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_SEL_W  = 4;
  localparam int FUNCT_W    = 6;
  localparam int SHAMT_W    = 5;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL   = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL   = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA   = 6'h03;
  localparam logic [FUNCT_W-1:0] FUNCT_SLLV  = 6'h04;
  localparam logic [FUNCT_W-1:0] FUNCT_SRLV  = 6'h06;
  localparam logic [FUNCT_W-1:0] FUNCT_SRAV  = 6'h07;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU  = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU  = 6'h23;
  localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR   = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR   = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'h2A;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  // Magnitude of a signed operand; unsigned operands pass unchanged.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic is_signed);
    if (is_signed && v[DATA_W-1]) begin
      return neg_val(v);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one shift-subtract step per cycle on operand
// magnitudes, with the sign fixup applied to the presented results.
module ex_stage_div_iter
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_t        state_r;
  div_state_t        state_next_s;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] dvsr_r;
  logic              q_neg_r;
  logic              r_neg_r;
  logic [DATA_W:0]   trial_s;
  logic              fits_s;

  // The quotient register doubles as the dividend shift register.
  assign trial_s = {rem_r, quo_r[DATA_W-1]} - {1'b0, dvsr_r};
  assign fits_s  = ~trial_s[DATA_W];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (start) begin
          state_next_s = DIV_BUSY;
        end else begin
          state_next_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (count_r == CNT_LAST) begin
          state_next_s = DIV_DONE;
        end else begin
          state_next_s = DIV_BUSY;
        end
      end
      DIV_DONE: state_next_s = DIV_IDLE;
      default:  state_next_s = DIV_IDLE;
    endcase
  end

  // Operand capture and shift-subtract datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
      quo_r   <= {DATA_W{1'b0}};
      rem_r   <= {DATA_W{1'b0}};
      dvsr_r  <= {DATA_W{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
            count_r <= {CNT_W{1'b0}};
            quo_r   <= abs_val(dividend, is_signed);
            rem_r   <= {DATA_W{1'b0}};
            dvsr_r  <= abs_val(divisor, is_signed);
            q_neg_r <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            r_neg_r <= is_signed & dividend[DATA_W-1];
          end
        end
        DIV_BUSY: begin
          count_r <= count_r + CNT_W'(1);
          quo_r   <= {quo_r[DATA_W-2:0], fits_s};
          rem_r   <= fits_s ? trial_s[DATA_W-1:0] : {rem_r[DATA_W-2:0], quo_r[DATA_W-1]};
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign busy      = (state_r == DIV_BUSY);
  assign done      = (state_r == DIV_DONE);
  assign quotient  = q_neg_r ? neg_val(quo_r) : quo_r;
  assign remainder = r_neg_r ? neg_val(rem_r) : rem_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, shifter, single-cycle multiplier, HI/LO registers and
// an iterative divider that freezes the front of the pipeline while it runs.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FUNCT_W-1:0]    funct_in,
  input  logic [SHAMT_W-1:0]    shamt_in,
  input  logic [DATA_W-1:0]     operand_1_in,
  input  logic [DATA_W-1:0]     operand_2_in,
  input  logic                  mem_read_flag_in,
  input  logic                  mem_write_flag_in,
  input  logic                  mem_ext_flag_in,
  input  logic [MEM_SEL_W-1:0]  mem_sel_in,
  input  logic [DATA_W-1:0]     mem_write_data_in,
  input  logic                  reg_write_en_in,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
  input  logic [ADDR_W-1:0]     current_pc_addr_in,
  output logic [DATA_W-1:0]     result_out,
  output logic                  mem_read_flag_out,
  output logic                  mem_write_flag_out,
  output logic                  mem_ext_flag_out,
  output logic [MEM_SEL_W-1:0]  mem_sel_out,
  output logic [DATA_W-1:0]     mem_write_data_out,
  output logic                  reg_write_en_out,
  output logic [REG_ADDR_W-1:0] reg_write_addr_out,
  output logic [ADDR_W-1:0]     current_pc_addr_out,
  output logic                  stall_request
);

  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic [DATA_W-1:0]   alu_s;
  logic                mult_signed_s;
  logic [2*DATA_W-1:0] op1_ext_s;
  logic [2*DATA_W-1:0] op2_ext_s;
  logic [2*DATA_W-1:0] prod_s;
  logic                is_div_s;
  logic                op2_nz_s;
  logic                div_busy_s;
  logic                div_done_s;
  logic                div_idle_s;
  logic                div_start_s;
  logic [DATA_W-1:0]   div_quo_s;
  logic [DATA_W-1:0]   div_rem_s;

  // One 64-bit multiplier serves both MULT and MULTU via the extension choice.
  assign mult_signed_s = (funct_in == FUNCT_MULT);
  assign op1_ext_s     = {{DATA_W{mult_signed_s & operand_1_in[DATA_W-1]}}, operand_1_in};
  assign op2_ext_s     = {{DATA_W{mult_signed_s & operand_2_in[DATA_W-1]}}, operand_2_in};
  assign prod_s        = op1_ext_s * op2_ext_s;

  assign is_div_s    = (funct_in == FUNCT_DIV) || (funct_in == FUNCT_DIVU);
  assign op2_nz_s    = (operand_2_in != {DATA_W{1'b0}});
  assign div_idle_s  = ~div_busy_s & ~div_done_s;
  assign div_start_s = div_idle_s & is_div_s & op2_nz_s;

  ex_stage_div_iter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .is_signed (funct_in == FUNCT_DIV),
    .dividend  (operand_1_in),
    .divisor   (operand_2_in),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // ALU and shifter result selection
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (funct_in)
      FUNCT_ADD, FUNCT_ADDU: alu_s = operand_1_in + operand_2_in;
      FUNCT_SUB, FUNCT_SUBU: alu_s = operand_1_in - operand_2_in;
      FUNCT_AND:  alu_s = operand_1_in & operand_2_in;
      FUNCT_OR:   alu_s = operand_1_in | operand_2_in;
      FUNCT_XOR:  alu_s = operand_1_in ^ operand_2_in;
      FUNCT_NOR:  alu_s = ~(operand_1_in | operand_2_in);
      FUNCT_SLT:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(operand_1_in) < $signed(operand_2_in))};
      FUNCT_SLTU: alu_s = {{(DATA_W-1){1'b0}}, (operand_1_in < operand_2_in)};
      FUNCT_SLL:  alu_s = operand_2_in << shamt_in;
      FUNCT_SRL:  alu_s = operand_2_in >> shamt_in;
      FUNCT_SRA:  alu_s = $signed(operand_2_in) >>> shamt_in;
      FUNCT_SLLV: alu_s = operand_2_in << operand_1_in[SHAMT_W-1:0];
      FUNCT_SRLV: alu_s = operand_2_in >> operand_1_in[SHAMT_W-1:0];
      FUNCT_SRAV: alu_s = $signed(operand_2_in) >>> operand_1_in[SHAMT_W-1:0];
      FUNCT_MFHI: alu_s = hi_r;
      FUNCT_MFLO: alu_s = lo_r;
      default:    alu_s = {DATA_W{1'b0}};
    endcase
  end

  // HI/LO update; a finishing divide takes priority over the ops on the inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= {DATA_W{1'b0}};
      lo_r <= {DATA_W{1'b0}};
    end else if (div_done_s) begin
      hi_r <= div_rem_s;
      lo_r <= div_quo_s;
    end else if (div_idle_s) begin
      case (funct_in)
        FUNCT_MTHI: hi_r <= operand_1_in;
        FUNCT_MTLO: lo_r <= operand_1_in;
        FUNCT_MULT, FUNCT_MULTU: begin
          hi_r <= prod_s[2*DATA_W-1:DATA_W];
          lo_r <= prod_s[DATA_W-1:0];
        end
        FUNCT_DIV, FUNCT_DIVU: begin
          if (!op2_nz_s) begin
            hi_r <= operand_1_in;
            lo_r <= {DATA_W{1'b1}};
          end
        end
        default: begin
          hi_r <= hi_r;
        end
      endcase
    end
  end

  // Output drive, held at zero while reset is asserted
  always_comb begin
    if (rst) begin
      result_out          = {DATA_W{1'b0}};
      mem_read_flag_out   = 1'b0;
      mem_write_flag_out  = 1'b0;
      mem_ext_flag_out    = 1'b0;
      mem_sel_out         = {MEM_SEL_W{1'b0}};
      mem_write_data_out  = {DATA_W{1'b0}};
      reg_write_en_out    = 1'b0;
      reg_write_addr_out  = {REG_ADDR_W{1'b0}};
      current_pc_addr_out = {ADDR_W{1'b0}};
      stall_request       = 1'b0;
    end else begin
      result_out          = alu_s;
      mem_read_flag_out   = mem_read_flag_in;
      mem_write_flag_out  = mem_write_flag_in;
      mem_ext_flag_out    = mem_ext_flag_in;
      mem_sel_out         = mem_sel_in;
      mem_write_data_out  = mem_write_data_in;
      reg_write_en_out    = reg_write_en_in;
      reg_write_addr_out  = reg_write_addr_in;
      current_pc_addr_out = current_pc_addr_in;
      stall_request       = div_start_s | div_busy_s;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected values, a
// negedge monitor compares outputs and measures divider stall run lengths.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  funct_in;
  logic [4:0]  shamt_in;
  logic [31:0] operand_1_in, operand_2_in;
  logic        mem_read_flag_in, mem_write_flag_in, mem_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic [31:0] result_out;
  logic        mem_read_flag_out, mem_write_flag_out, mem_ext_flag_out;
  logic [3:0]  mem_sel_out;
  logic [31:0] mem_write_data_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;
  logic        stall_request;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .funct_in(funct_in), .shamt_in(shamt_in),
    .operand_1_in(operand_1_in), .operand_2_in(operand_2_in),
    .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
    .mem_ext_flag_in(mem_ext_flag_in), .mem_sel_in(mem_sel_in),
    .mem_write_data_in(mem_write_data_in), .reg_write_en_in(reg_write_en_in),
    .reg_write_addr_in(reg_write_addr_in), .current_pc_addr_in(current_pc_addr_in),
    .result_out(result_out), .mem_read_flag_out(mem_read_flag_out),
    .mem_write_flag_out(mem_write_flag_out), .mem_ext_flag_out(mem_ext_flag_out),
    .mem_sel_out(mem_sel_out), .mem_write_data_out(mem_write_data_out),
    .reg_write_en_out(reg_write_en_out), .reg_write_addr_out(reg_write_addr_out),
    .current_pc_addr_out(current_pc_addr_out), .stall_request(stall_request)
  );

  always #5 clk = ~clk;

  // kind: 0 result, 1 stall, 2 pc, 3 packed controls, 4 timeout, 5 leftover stalls
  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } chk_t;

  chk_t res_q[$];
  int   stall_q[$];
  int   errors = 0;
  int   checks = 0;
  int   run_len = 0;

  task automatic chk(input int kind, input string name, input logic [31:0] exp);
    chk_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = exp;
    res_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    funct_in     = f;
    shamt_in     = sh;
    operand_1_in = a;
    operand_2_in = b;
  endtask

  // Hold a divide on the inputs until stall drops (the DONE cycle).
  task automatic wait_div(input string name);
    bit seen_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!stall_request) begin
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) chk(4, name, 32'd1);
  endtask

  // Monitor: stall run lengths and queued output comparisons
  always @(negedge clk) begin
    logic [31:0] act;
    chk_t e;
    if (stall_request) begin
      run_len++;
    end else if (run_len != 0) begin
      checks++;
      if (stall_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stall: got %0d cycles, required none", run_len);
      end else begin
        int exp_len;
        exp_len = stall_q.pop_front();
        if (run_len != exp_len) begin
          errors++;
          $display("FAIL stall_len: got %0d cycles, required %0d", run_len, exp_len);
        end
      end
      run_len = 0;
    end
    while (res_q.size() > 0) begin
      e = res_q.pop_front();
      case (e.kind)
        0: act = result_out;
        1: act = {31'd0, stall_request};
        2: act = current_pc_addr_out;
        3: act = {19'd0, mem_read_flag_out, mem_write_flag_out, mem_ext_flag_out,
                  mem_sel_out, reg_write_en_out, reg_write_addr_out};
        4: act = 32'd0;
        5: act = 32'(stall_q.size());
        default: act = 32'hDEAD_BEEF;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h, required 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    rst                = 1'b1;
    mem_read_flag_in   = 1'b1;
    mem_write_flag_in  = 1'b0;
    mem_ext_flag_in    = 1'b1;
    mem_sel_in         = 4'b0011;
    mem_write_data_in  = 32'h1357_9BDF;
    reg_write_en_in    = 1'b1;
    reg_write_addr_in  = 5'd17;
    current_pc_addr_in = 32'h0040_0010;
    drive(FUNCT_ADD, 5'd0, 32'd5, 32'd6);
    #1;
    chk(0, "rst_result", 32'd0);
    chk(2, "rst_pc", 32'd0);
    chk(3, "rst_ctrl", 32'd0);
    step(); drive(FUNCT_DIV, 5'd0, 32'd10, 32'd2); chk(1, "rst_stall", 32'd0);
    step(); rst = 1'b0; drive(FUNCT_SLL, 5'd0, 32'd0, 32'd0);
    chk(1, "idle_stall", 32'd0);
    chk(2, "pc_pass", 32'h0040_0010);
    chk(3, "ctrl_pass", 32'h0000_14F1);
    step(); drive(FUNCT_MFHI, 5'd0, 32'd0, 32'd0); chk(0, "hi_reset", 32'd0);
    step(); drive(FUNCT_MFLO, 5'd0, 32'd0, 32'd0); chk(0, "lo_reset", 32'd0);

    // Single-cycle ALU and shifter ops
    step(); drive(FUNCT_ADD,  5'd0, 32'h7FFF_FFFF, 32'd1);  chk(0, "add_wrap", 32'h8000_0000);
    step(); drive(FUNCT_SLT,  5'd0, 32'hFFFF_FFFF, 32'd1);  chk(0, "slt", 32'd1);
    step(); drive(FUNCT_SLTU, 5'd0, 32'hFFFF_FFFF, 32'd1);  chk(0, "sltu", 32'd0);
    step(); drive(FUNCT_SRA,  5'd4, 32'd0, 32'h8000_0000);  chk(0, "sra", 32'hF800_0000);
    step(); drive(FUNCT_SRL,  5'd4, 32'd0, 32'h8000_0000);  chk(0, "srl", 32'h0800_0000);
    step(); drive(FUNCT_SLLV, 5'd0, 32'h0000_0024, 32'd1);  chk(0, "sllv", 32'h0000_0010);
    step(); drive(FUNCT_SUBU, 5'd0, 32'd5, 32'd7);          chk(0, "sub_wrap", 32'hFFFF_FFFE);
    step(); drive(FUNCT_NOR,  5'd0, 32'd0, 32'd0);          chk(0, "nor", 32'hFFFF_FFFF);
    step(); drive(FUNCT_XOR,  5'd0, 32'h0000_F0F0, 32'h0000_FF00); chk(0, "xor", 32'h0000_0FF0);
    step(); drive(FUNCT_AND,  5'd0, 32'h0000_F0F0, 32'h0000_FF00); chk(0, "and", 32'h0000_F000);
    step(); drive(6'h3F,      5'd0, 32'h1234_5678, 32'd1);  chk(0, "undef", 32'd0);

    // Multiplier and HI/LO moves
    step(); drive(FUNCT_MULT,  5'd0, 32'hFFFF_FFFD, 32'd5); chk(0, "mult_result", 32'd0);
    step(); drive(FUNCT_MFHI,  5'd0, 32'd0, 32'd0);         chk(0, "mult_hi", 32'hFFFF_FFFF);
    step(); drive(FUNCT_MFLO,  5'd0, 32'd0, 32'd0);         chk(0, "mult_lo", 32'hFFFF_FFF1);
    step(); drive(FUNCT_MULTU, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); drive(FUNCT_MFHI,  5'd0, 32'd0, 32'd0);         chk(0, "multu_hi", 32'hFFFF_FFFE);
    step(); drive(FUNCT_MFLO,  5'd0, 32'd0, 32'd0);         chk(0, "multu_lo", 32'd1);
    step(); drive(FUNCT_MTHI,  5'd0, 32'hCAFE_0001, 32'd0); chk(0, "mthi_result", 32'd0);
    step(); drive(FUNCT_MTLO,  5'd0, 32'h0BAD_0002, 32'd0);
    step(); drive(FUNCT_MFHI,  5'd0, 32'd0, 32'd0);         chk(0, "mthi", 32'hCAFE_0001);
    step(); drive(FUNCT_MFLO,  5'd0, 32'd0, 32'd0);         chk(0, "mtlo", 32'h0BAD_0002);

    // Signed divide -7 / 2
    step(); drive(FUNCT_DIV, 5'd0, 32'hFFFF_FFF9, 32'd2);
    stall_q.push_back(33);
    chk(1, "div_stall_start", 32'd1);
    wait_div("div_m7_timeout");
    step(); drive(FUNCT_MFLO, 5'd0, 32'd0, 32'd0); chk(0, "div_lo", 32'hFFFF_FFFD);
    step(); drive(FUNCT_MFHI, 5'd0, 32'd0, 32'd0); chk(0, "div_hi", 32'hFFFF_FFFF);

    // Divide by zero
    step(); drive(FUNCT_DIVU, 5'd0, 32'd100, 32'd0); chk(1, "divz_stall", 32'd0);
    step(); drive(FUNCT_MFHI, 5'd0, 32'd0, 32'd0);   chk(0, "divz_hi", 32'd100);
    step(); drive(FUNCT_MFLO, 5'd0, 32'd0, 32'd0);   chk(0, "divz_lo", 32'hFFFF_FFFF);

    // Back-to-back divides, the second being the overflow corner
    step(); drive(FUNCT_DIVU, 5'd0, 32'd100, 32'd7);
    stall_q.push_back(33);
    wait_div("div_b2b1_timeout");
    step(); drive(FUNCT_DIV, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    stall_q.push_back(33);
    wait_div("div_b2b2_timeout");
    step(); drive(FUNCT_MFLO, 5'd0, 32'd0, 32'd0); chk(0, "div_ovf_lo", 32'h8000_0000);
    step(); drive(FUNCT_MFHI, 5'd0, 32'd0, 32'd0); chk(0, "div_ovf_hi", 32'd0);

    // Reset while the divider is at BUSY count 10
    step(); drive(FUNCT_MTHI, 5'd0, 32'h0000_1234, 32'd0);
    step(); drive(FUNCT_DIV, 5'd0, 32'd85, 32'd3);
    stall_q.push_back(11);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    chk(1, "abort_stall", 32'd0);
    chk(2, "abort_pc", 32'd0);
    step(); drive(FUNCT_SLL, 5'd0, 32'd0, 32'd0); rst = 1'b0;
    chk(1, "post_abort_stall", 32'd0);
    step(); drive(FUNCT_MFHI, 5'd0, 32'd0, 32'd0); chk(0, "abort_hi", 32'd0);
    step(); drive(FUNCT_MFLO, 5'd0, 32'd0, 32'd0); chk(0, "abort_lo", 32'd0);
    step(); drive(FUNCT_DIV, 5'd0, 32'd9, 32'd3);
    stall_q.push_back(33);
    wait_div("div_9_3_timeout");
    step(); drive(FUNCT_MFLO, 5'd0, 32'd0, 32'd0); chk(0, "div93_lo", 32'd3);
    step(); drive(FUNCT_MFHI, 5'd0, 32'd0, 32'd0); chk(0, "div93_hi", 32'd0);

    step(); drive(FUNCT_SLL, 5'd0, 32'd0, 32'd0);
    chk(5, "stalls_seen", 32'd0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
